// File: rtl/fft_frame_sequencer.sv
// Frames the decimated ADC sample stream into fixed-length blocks for the FFT engine,
// buffers them in a small FWFT skid FIFO, and collects the peak-bin index per frame.
module fft_frame_sequencer #(
  parameter int DATA_W     = 12,
  parameter int IDX_W      = 8,
  parameter int LEN_W      = 9,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 4096
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              start,
  input  logic              abort,
  input  logic              continuous,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic [3:0]        decim,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  output logic [DATA_W-1:0] fft_data,
  output logic              fft_valid,
  output logic              fft_sop,
  output logic              fft_eop,
  input  logic              fft_ready,
  input  logic [IDX_W-1:0]  fft_idx,
  input  logic              fft_idx_valid,
  output logic [IDX_W-1:0]  result_idx,
  output logic              result_valid,
  output logic              busy,
  output logic              overrun,
  output logic              timeout,
  output logic [15:0]       frame_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, ARM, CAPTURE, WAIT_RES, DONE} state_t;

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [3:0]        decim_q;
  logic [3:0]        decim_ctr;
  logic [LEN_W-1:0]  push_cnt;
  logic [LEN_W-1:0]  pop_cnt;
  logic [TMR_W-1:0]  timer;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    count;

  logic fifo_full;
  logic keep;
  logic pop;
  logic push;
  logic drop;

  assign fifo_full = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fft_valid = (state == CAPTURE) && (count != '0);
  assign fft_data  = mem[rd_ptr];
  assign fft_sop   = fft_valid && (pop_cnt == '0);
  assign fft_eop   = fft_valid && (pop_cnt == len_q - LEN_W'(1));
  assign busy      = (state != IDLE);

  // A kept sample still gets in when the FIFO is full if a beat leaves in the same cycle.
  assign keep = (state == CAPTURE) && adc_valid && (decim_ctr == '0) && (push_cnt < len_q);
  assign pop  = fft_valid && fft_ready;
  assign push = keep && (!fifo_full || pop);
  assign drop = keep && fifo_full && !pop;

  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr] <= adc_data;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state        <= IDLE;
      len_q        <= '0;
      decim_q      <= '0;
      decim_ctr    <= '0;
      push_cnt     <= '0;
      pop_cnt      <= '0;
      timer        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      result_idx   <= '0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      result_valid <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (frame_len != '0)) begin
              len_q   <= frame_len;
              decim_q <= decim;
              overrun <= 1'b0;
              timeout <= 1'b0;
              state   <= ARM;
            end
          end
          ARM: begin
            decim_ctr <= '0;
            push_cnt  <= '0;
            pop_cnt   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= CAPTURE;
          end
          CAPTURE: begin
            if (adc_valid) decim_ctr <= (decim_ctr == decim_q) ? 4'd0 : decim_ctr + 4'd1;
            if (drop) overrun <= 1'b1;
            if (push) begin
              wr_ptr   <= wr_ptr + PTR_W'(1);
              push_cnt <= push_cnt + LEN_W'(1);
            end
            if (pop) begin
              rd_ptr  <= rd_ptr + PTR_W'(1);
              pop_cnt <= pop_cnt + LEN_W'(1);
            end
            case ({push, pop})
              2'b10:   count <= count + (PTR_W+1)'(1);
              2'b01:   count <= count - (PTR_W+1)'(1);
              default: count <= count;
            endcase
            if (pop && fft_eop) begin
              timer <= '0;
              state <= WAIT_RES;
            end
          end
          WAIT_RES: begin
            if (fft_idx_valid) begin
              result_idx   <= fft_idx;
              result_valid <= 1'b1;
              frame_cnt    <= frame_cnt + 16'd1;
              state        <= DONE;
            end else if (timer == TMR_W'(TIMEOUT)) begin
              timeout <= 1'b1;
              state   <= DONE;
            end else begin
              timer <= timer + TMR_W'(1);
            end
          end
          DONE: begin
            state <= continuous ? ARM : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
